// File: rtl/port_match_pkg.sv
// Shared types and constants for the port-match scheduler: FSM states,
// comparator timing constants and the flagged-port table entry layout.
package port_match_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      CLEAR,
      FEED,
      FLUSH,
      SAMPLE,
      SKIP,
      REPORT
   } state_t;

   // The comparator needs CMP_LATENCY cycles from last word to match; the
   // SAMPLE cycle itself covers one of them, the flush words cover the rest.
   localparam int CMP_LATENCY = 3;
   localparam int FLUSH_WORDS = CMP_LATENCY - 1;

   typedef struct packed {
      logic        en;
      logic [15:0] port;
   } flag_entry_t;

endpackage

// File: rtl/port_flag_table.sv
// Flagged-port table: one write port, one combinational read port.
// Optional PORT_HIT_COUNT_EN adds per-entry 16-bit saturating hit counters.
module port_flag_table
   import port_match_pkg::*;
#(
   parameter int NUM_FLAGS = 8,
   parameter int IDX_W     = $clog2(NUM_FLAGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [IDX_W-1:0]     wr_addr,
   input  flag_entry_t          wr_entry,
   input  logic [IDX_W-1:0]     rd_addr,
`ifdef PORT_HIT_COUNT_EN
   input  logic [NUM_FLAGS-1:0] hit_inc,
   input  logic [IDX_W-1:0]     cnt_rd_addr,
   output logic [15:0]          cnt_rd_data,
`endif
   output flag_entry_t          rd_entry
);

   flag_entry_t entries [NUM_FLAGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_FLAGS; i++) begin
            entries[i] <= '0;
         end
      end else if (we) begin
         entries[wr_addr] <= wr_entry;
      end
   end

   assign rd_entry = entries[rd_addr];

`ifdef PORT_HIT_COUNT_EN
   logic [15:0] hits [NUM_FLAGS];

   // A table write restarts that entry's count, taking priority over a hit.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FLAGS; i++) begin
         if (rst) begin
            hits[i] <= '0;
         end else if (we && (wr_addr == IDX_W'(i))) begin
            hits[i] <= '0;
         end else if (hit_inc[i] && (hits[i] != 16'hFFFF)) begin
            hits[i] <= hits[i] + 16'd1;
         end
      end
   end

   assign cnt_rd_data = hits[cnt_rd_addr];
`endif

endmodule

// File: rtl/port_match_scheduler.sv
// Captures packet header words and replays them through one shared port comparator,
// once per enabled flag entry. Optional macro PORT_HIT_COUNT_EN adds hit counters.
module port_match_scheduler
   import port_match_pkg::*;
#(
   parameter int NUM_FLAGS = 8,
   parameter int CAP_WORDS = 4,
   parameter int IDX_W     = $clog2(NUM_FLAGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [IDX_W-1:0]     cfg_addr,
   input  logic [15:0]          cfg_port,
   input  logic                 cfg_en,
   input  logic                 in_valid,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic [31:0]          in_data,
   output logic                 in_ready,
   output logic                 cmp_clear,
   output logic [15:0]          cmp_flag_port,
   output logic [31:0]          cmp_data,
   input  logic                 cmp_match,
   output logic                 res_valid,
   input  logic                 res_ready,
`ifdef PORT_HIT_COUNT_EN
   input  logic [IDX_W-1:0]     cnt_rd_addr,
   output logic [15:0]          cnt_rd_data,
`endif
   output logic [NUM_FLAGS-1:0] res_match_vec,
   output logic                 res_any
);

   localparam int LEN_W  = $clog2(CAP_WORDS + 1);
   localparam int CAP_AW = $clog2(CAP_WORDS);

   state_t               state;
   logic [31:0]          cap_buf [CAP_WORDS];
   logic [LEN_W-1:0]     len;
   logic [LEN_W-1:0]     cnt;
   logic [IDX_W-1:0]     ent;
   logic [IDX_W-1:0]     nxt_ent;
   logic [NUM_FLAGS-1:0] vec;
   logic [NUM_FLAGS-1:0] vec_upd;
   flag_entry_t          wr_entry;
   flag_entry_t          rd_entry;
   logic                 accept;
   logic                 scan_step;
   logic                 last_ent;
   logic                 ent_live;
   logic                 cap_done;
   logic                 start_entry;

   assign wr_entry.en   = cfg_en;
   assign wr_entry.port = cfg_port;

   port_flag_table #(
      .NUM_FLAGS (NUM_FLAGS),
      .IDX_W     (IDX_W)
   ) u_table (
      .clk         (clk),
      .rst         (rst),
      .we          (cfg_we),
      .wr_addr     (cfg_addr),
      .wr_entry    (wr_entry),
      .rd_addr     (nxt_ent),
`ifdef PORT_HIT_COUNT_EN
      .hit_inc     ((res_valid && res_ready) ? res_match_vec : '0),
      .cnt_rd_addr (cnt_rd_addr),
      .cnt_rd_data (cnt_rd_data),
`endif
      .rd_entry    (rd_entry)
   );

   assign in_ready    = (state == IDLE) || (state == CAPTURE);
   assign accept      = in_valid && in_ready;
   assign scan_step   = (state == SAMPLE) || (state == SKIP);
   assign last_ent    = (ent == IDX_W'(NUM_FLAGS - 1));
   assign nxt_ent     = scan_step ? ent + 1'b1 : '0;
   assign ent_live    = rd_entry.en && (rd_entry.port != 16'h0000);
   assign cap_done    = accept && in_eop && ((state == CAPTURE) || in_sop);
   assign start_entry = cap_done || (scan_step && !last_ent);

   always_comb begin
      vec_upd = vec;
      if (state == SAMPLE) begin
         vec_upd[ent] = cmp_match;
      end else if (state == SKIP) begin
         vec_upd[ent] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         len           <= '0;
         cnt           <= '0;
         ent           <= '0;
         vec           <= '0;
         cmp_clear     <= 1'b0;
         cmp_flag_port <= '0;
         cmp_data      <= '0;
         res_valid     <= 1'b0;
         res_match_vec <= '0;
         res_any       <= 1'b0;
         for (int i = 0; i < CAP_WORDS; i++) begin
            cap_buf[i] <= '0;
         end
      end else begin
         cmp_clear <= 1'b0;
         cmp_data  <= '0;
         case (state)
            IDLE: begin
               if (accept && in_sop) begin
                  cap_buf[0] <= in_data;
                  len        <= LEN_W'(1);
                  state      <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (accept) begin
                  if (in_sop) begin
                     cap_buf[0] <= in_data;
                     len        <= LEN_W'(1);
                  end else if (len < LEN_W'(CAP_WORDS)) begin
                     cap_buf[len[CAP_AW-1:0]] <= in_data;
                     len                      <= len + 1'b1;
                  end
               end
            end
            CLEAR: begin
               cmp_data <= cap_buf[0];
               cnt      <= LEN_W'(1);
               state    <= FEED;
            end
            FEED: begin
               if (cnt == len) begin
                  cnt   <= '0;
                  state <= FLUSH;
               end else begin
                  cmp_data <= cap_buf[cnt[CAP_AW-1:0]];
                  cnt      <= cnt + 1'b1;
               end
            end
            FLUSH: begin
               if (cnt == LEN_W'(FLUSH_WORDS - 1)) begin
                  state <= SAMPLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SAMPLE, SKIP: begin
               vec <= vec_upd;
               if (last_ent) begin
                  res_valid     <= 1'b1;
                  res_match_vec <= vec_upd;
                  res_any       <= |vec_upd;
                  state         <= REPORT;
               end
            end
            REPORT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Entry dispatch overrides the per-state next state; the port is
         // latched here so later table writes cannot disturb this entry.
         if (start_entry) begin
            ent <= nxt_ent;
            if (ent_live) begin
               cmp_clear     <= 1'b1;
               cmp_flag_port <= rd_entry.port;
               state         <= CLEAR;
            end else begin
               state <= SKIP;
            end
         end
      end
   end

endmodule
